// File: rtl/sdc_pkg.sv
// Shared types and constants for the floppy sector server: FSM states,
// sector geometry and the image-relative byte offset helper.
package sdc_pkg;

  localparam int SECTOR_BYTES = 512;
  localparam int LBA_W        = 11;
  localparam int CNT_W        = 9;
  localparam int TALLY_W      = 10;

  localparam logic [TALLY_W-1:0] TALLY_FULL = TALLY_W'(SECTOR_BYTES);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    XFER,
    FILL,
    DONE,
    RELEASE
  } state_t;

  // Byte offset of a sector inside the image, widened to 32 bits before the shift.
  function automatic logic [31:0] sector_offset(input logic [LBA_W-1:0] lba);
    return {12'd0, lba, 9'd0};
  endfunction

endpackage

// File: rtl/sd_sector_server_if.sv
// Signal bundle between the Mac core sector port, the SD block driver and
// the sector server; the server uses the slave view, the surroundings the master view.
interface sd_sector_server_if;
  import sdc_pkg::*;

  // mount status
  logic [1:0]       img_present;
  logic [31:0]      img_size_in;
  logic [1:0]       sdc_image_mounted;
  logic [31:0]      sdc_image_size;

  // core sector request side
  logic [1:0]       sdc_rd;
  logic [1:0]       sdc_wr;
  logic [LBA_W-1:0] sdc_lba;
  logic             sdc_busy;
  logic             sdc_done;
  logic [7:0]       sdc_data_in;
  logic             sdc_data_en;
  logic [8:0]       sdc_addr;
  logic [7:0]       sdc_data_out;

  // SD block driver side
  logic [31:0]      sd_lba;
  logic             sd_rd;
  logic             sd_wr;
  logic             sd_busy;
  logic [7:0]       sd_rdata;
  logic             sd_rdata_valid;
  logic             sd_wdata_req;
  logic [7:0]       sd_wdata;
  logic             sd_wdata_valid;
  logic             sd_done;
  logic             sd_err;

  logic             err;

  modport slave (
    input  img_present, img_size_in,
    output sdc_image_mounted, sdc_image_size,
    input  sdc_rd, sdc_wr, sdc_lba, sdc_data_out,
    output sdc_busy, sdc_done, sdc_data_in, sdc_data_en, sdc_addr,
    output sd_lba, sd_rd, sd_wr, sd_wdata, sd_wdata_valid,
    input  sd_busy, sd_rdata, sd_rdata_valid, sd_wdata_req, sd_done, sd_err,
    output err
  );

  modport master (
    output img_present, img_size_in,
    input  sdc_image_mounted, sdc_image_size,
    output sdc_rd, sdc_wr, sdc_lba, sdc_data_out,
    input  sdc_busy, sdc_done, sdc_data_in, sdc_data_en, sdc_addr,
    input  sd_lba, sd_rd, sd_wr, sd_wdata, sd_wdata_valid,
    output sd_busy, sd_rdata, sd_rdata_valid, sd_wdata_req, sd_done, sd_err,
    input  err
  );

endinterface

// File: rtl/sd_sector_server.sv
// Serves per-drive floppy sector reads/writes from the Mac core by driving a
// byte-stream SD block driver at the absolute card sector of each image.
module sd_sector_server
  import sdc_pkg::*;
#(
  parameter int          DRIVES    = 2,
  parameter logic [31:0] IMG_BASE0 = 32'd0,
  parameter logic [31:0] IMG_BASE1 = 32'd1600
) (
  input logic               clk,
  input logic               reset,
  sd_sector_server_if.slave bus
);

  state_t             state_q, state_d;
  logic               drive_q, drive_d;
  logic               wr_q, wr_d;
  logic [LBA_W-1:0]   lba_q, lba_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [TALLY_W-1:0] tally_q, tally_d;
  logic               err_q, err_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               data_en_q, data_en_d;
  logic [7:0]         data_in_q, data_in_d;
  logic [8:0]         addr_q, addr_d;
  logic [31:0]        sd_lba_q, sd_lba_d;
  logic               sd_rd_q, sd_rd_d;
  logic               sd_wr_q, sd_wr_d;
  logic               wstage_q, wstage_d;
  logic [7:0]         wdata_q, wdata_d;
  logic               wvalid_q, wvalid_d;
  logic [1:0]         mounted_q, mounted_d;
  logic [31:0]        size_q, size_d;

  logic [DRIVES-1:0]  req_any;
  logic               sel_rd;
  logic [31:0]        base;

  assign req_any = bus.sdc_rd | bus.sdc_wr;
  assign base    = drive_q ? IMG_BASE1 : IMG_BASE0;

  always_comb begin
    // NOTE: every _d takes its hold/default value before the case, so no
    // path through the decode can leave a signal unassigned and infer a latch.
    state_d   = state_q;
    drive_d   = drive_q;
    wr_d      = wr_q;
    lba_d     = lba_q;
    cnt_d     = cnt_q;
    tally_d   = tally_q;
    err_d     = err_q;
    data_en_d = 1'b0;
    data_in_d = data_in_q;
    addr_d    = addr_q;
    sd_lba_d  = sd_lba_q;
    sd_rd_d   = sd_rd_q;
    sd_wr_d   = sd_wr_q;
    wstage_d  = 1'b0;
    wdata_d   = wdata_q;
    wvalid_d  = 1'b0;
    sel_rd    = 1'b0;
    mounted_d = bus.img_present;
    size_d    = bus.img_size_in;

    // Second write-pipeline stage runs regardless of state so the last byte
    // still reaches the driver if sd_done lands right behind its request.
    if (wstage_q) begin
      wdata_d  = bus.sdc_data_out;
      wvalid_d = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (|req_any) begin
          drive_d = ~req_any[0];
          sel_rd  = drive_d ? bus.sdc_rd[1] : bus.sdc_rd[0];
          wr_d    = ~sel_rd;
          lba_d   = bus.sdc_lba;
          cnt_d   = '0;
          tally_d = '0;
          state_d = ISSUE;
          if (!bus.img_present[drive_d]) begin
            state_d = DONE;
            err_d   = 1'b1;
          end else if (sector_offset(bus.sdc_lba) >= bus.img_size_in) begin
            state_d = sel_rd ? FILL : DONE;
          end
        end
      end

      ISSUE: begin
        if ((sd_rd_q || sd_wr_q) && bus.sd_busy) begin
          sd_rd_d = 1'b0;
          sd_wr_d = 1'b0;
          state_d = XFER;
        end else begin
          sd_rd_d  = ~wr_q;
          sd_wr_d  = wr_q;
          sd_lba_d = base + {21'd0, lba_q};
        end
      end

      XFER: begin
        if (!wr_q && bus.sd_rdata_valid) begin
          if (tally_q == TALLY_FULL) begin
            err_d = 1'b1;
          end else begin
            data_en_d = 1'b1;
            data_in_d = bus.sd_rdata;
            addr_d    = cnt_q;
            cnt_d     = cnt_q + 9'd1;
            tally_d   = tally_q + 10'd1;
          end
        end
        if (wr_q && bus.sd_wdata_req) begin
          addr_d   = cnt_q;
          cnt_d    = cnt_q + 9'd1;
          wstage_d = 1'b1;
          if (tally_q != TALLY_FULL) tally_d = tally_q + 10'd1;
        end
        if (bus.sd_err) err_d = 1'b1;
        if (bus.sd_done) begin
          state_d = DONE;
          if (tally_d != TALLY_FULL) err_d = 1'b1;
        end
      end

      // Out-of-range reads return a zero sector without touching the card.
      FILL: begin
        if (tally_q == TALLY_FULL) begin
          state_d = DONE;
        end else begin
          data_en_d = 1'b1;
          data_in_d = 8'h00;
          addr_d    = cnt_q;
          cnt_d     = cnt_q + 9'd1;
          tally_d   = tally_q + 10'd1;
        end
      end

      DONE: state_d = RELEASE;

      RELEASE: begin
        if (!(|req_any)) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of the others, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      drive_q   <= 1'b0;
      wr_q      <= 1'b0;
      lba_q     <= '0;
      cnt_q     <= '0;
      tally_q   <= '0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      data_en_q <= 1'b0;
      data_in_q <= '0;
      addr_q    <= '0;
      sd_lba_q  <= '0;
      sd_rd_q   <= 1'b0;
      sd_wr_q   <= 1'b0;
      wstage_q  <= 1'b0;
      wdata_q   <= '0;
      wvalid_q  <= 1'b0;
      mounted_q <= '0;
      size_q    <= '0;
    end else begin
      state_q   <= state_d;
      drive_q   <= drive_d;
      wr_q      <= wr_d;
      lba_q     <= lba_d;
      cnt_q     <= cnt_d;
      tally_q   <= tally_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      data_en_q <= data_en_d;
      data_in_q <= data_in_d;
      addr_q    <= addr_d;
      sd_lba_q  <= sd_lba_d;
      sd_rd_q   <= sd_rd_d;
      sd_wr_q   <= sd_wr_d;
      wstage_q  <= wstage_d;
      wdata_q   <= wdata_d;
      wvalid_q  <= wvalid_d;
      mounted_q <= mounted_d;
      size_q    <= size_d;
    end
  end

  assign bus.sdc_image_mounted = mounted_q;
  assign bus.sdc_image_size    = size_q;
  assign bus.sdc_busy          = busy_q;
  assign bus.sdc_done          = done_q;
  assign bus.sdc_data_in       = data_in_q;
  assign bus.sdc_data_en       = data_en_q;
  assign bus.sdc_addr          = addr_q;
  assign bus.sd_lba            = sd_lba_q;
  assign bus.sd_rd             = sd_rd_q;
  assign bus.sd_wr             = sd_wr_q;
  assign bus.sd_wdata          = wdata_q;
  assign bus.sd_wdata_valid    = wvalid_q;
  assign bus.err               = err_q;

endmodule

// File: tb/tb_sd_sector_server.sv
// Directed bench for sd_sector_server: a driver/core model schedules the
// expected strobes by cycle number and one negedge process compares them.
module tb_sd_sector_server;
  import sdc_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sd_sector_server_if ifc();

  sd_sector_server #(
    .DRIVES   (2),
    .IMG_BASE0(32'd0),
    .IMG_BASE1(32'd1600)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (ifc)
  );

  // Core model: write data returned for an address is its low byte.
  assign ifc.sdc_data_out = ifc.sdc_addr[7:0];

  typedef struct {
    int         cyc;
    logic [8:0] addr;
    logic [7:0] data;
  } exp_t;

  exp_t rd_q[$];
  exp_t wa_q[$];
  exp_t wd_q[$];
  int   dn_q[$];

  int cyc = 0;
  int n_checks = 0;
  int n_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Per-cycle comparison of every strobe against its scheduled expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (rd_q.size() > 0 && rd_q[0].cyc == cyc) begin
        e = rd_q.pop_front();
        check("rd_strobe", 32'(ifc.sdc_data_en), 32'd1);
        check("rd_addr", 32'(ifc.sdc_addr), 32'(e.addr));
        check("rd_data", 32'(ifc.sdc_data_in), 32'(e.data));
      end else begin
        check("rd_strobe_quiet", 32'(ifc.sdc_data_en), 32'd0);
      end
      if (wa_q.size() > 0 && wa_q[0].cyc == cyc) begin
        e = wa_q.pop_front();
        check("wr_addr", 32'(ifc.sdc_addr), 32'(e.addr));
      end
      if (wd_q.size() > 0 && wd_q[0].cyc == cyc) begin
        e = wd_q.pop_front();
        check("wr_valid", 32'(ifc.sd_wdata_valid), 32'd1);
        check("wr_data", 32'(ifc.sd_wdata), 32'(e.data));
      end else begin
        check("wr_valid_quiet", 32'(ifc.sd_wdata_valid), 32'd0);
      end
      if (dn_q.size() > 0 && dn_q[0] == cyc) begin
        void'(dn_q.pop_front());
        check("done_pulse", 32'(ifc.sdc_done), 32'd1);
      end else begin
        check("done_quiet", 32'(ifc.sdc_done), 32'd0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctrl"}, 32'({ifc.sdc_busy, ifc.sdc_done, ifc.sdc_data_en, ifc.sd_rd,
                               ifc.sd_wr, ifc.sd_wdata_valid, ifc.err}), 32'd0);
    check({tag, "_bytes"}, 32'({ifc.sdc_image_mounted, ifc.sdc_addr, ifc.sdc_data_in,
                                ifc.sd_wdata}), 32'd0);
    check({tag, "_sd_lba"}, ifc.sd_lba, 32'd0);
    check({tag, "_size"}, ifc.sdc_image_size, 32'd0);
  endtask

  task automatic request(input logic [1:0] rd, input logic [1:0] wr, input logic [10:0] lba,
                         output int t);
    tick();
    ifc.sdc_rd  = rd;
    ifc.sdc_wr  = wr;
    ifc.sdc_lba = lba;
    t = cyc;
    tick();
    check("busy_rise", 32'(ifc.sdc_busy), 32'd1);
  endtask

  // Driver side of ISSUE: see the request level, check it, answer with busy.
  task automatic issue_wait(input int exp_rise, input logic want_wr, input logic [31:0] exp_lba,
                            output bit ok);
    int c = -1;
    for (int k = 0; k < 8 && c < 0; k++) begin
      tick();
      if (want_wr ? ifc.sd_wr : ifc.sd_rd) c = cyc;
    end
    check("sd_req_rise_cyc", c, exp_rise);
    ok = (c >= 0);
    if (ok) begin
      check("sd_lba", ifc.sd_lba, exp_lba);
      check("sd_req_other_quiet", 32'(want_wr ? ifc.sd_rd : ifc.sd_wr), 32'd0);
      ifc.sd_busy = 1'b1;
      tick();
      check("sd_req_drop", 32'(ifc.sd_rd | ifc.sd_wr), 32'd0);
    end
  endtask

  task automatic drv_read(input int n, input bit with_done, input bit err_pulse);
    for (int i = 0; i < n; i++) begin
      tick();
      ifc.sd_rdata_valid = 1'b1;
      ifc.sd_rdata       = 8'(i) ^ 8'hA5;
      rd_q.push_back('{cyc: cyc + 1, addr: 9'(i), data: 8'(i) ^ 8'hA5});
    end
    tick();
    ifc.sd_rdata_valid = 1'b0;
    if (with_done) begin
      ifc.sd_done = 1'b1;
      ifc.sd_err  = err_pulse;
      dn_q.push_back(cyc + 1);
      tick();
      ifc.sd_done = 1'b0;
      ifc.sd_err  = 1'b0;
      ifc.sd_busy = 1'b0;
    end
  endtask

  task automatic drv_write(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      ifc.sd_wdata_req = 1'b1;
      wa_q.push_back('{cyc: cyc + 1, addr: 9'(i), data: 8'h00});
      wd_q.push_back('{cyc: cyc + 2, addr: 9'(i), data: 8'(i)});
      if (i % 3 == 2) begin
        tick();
        ifc.sd_wdata_req = 1'b0;
      end
    end
    tick();
    ifc.sd_wdata_req = 1'b0;
    tick();
    tick();
    ifc.sd_done = 1'b1;
    dn_q.push_back(cyc + 1);
    tick();
    ifc.sd_done = 1'b0;
    ifc.sd_busy = 1'b0;
  endtask

  task automatic wait_idle();
    int k = 0;
    while (ifc.sdc_busy && k < 40) begin
      tick();
      k++;
    end
    check("busy_release", 32'(ifc.sdc_busy), 32'd0);
    tick();
  endtask

  task automatic release_req();
    tick();
    ifc.sdc_rd = 2'b00;
    ifc.sdc_wr = 2'b00;
    wait_idle();
  endtask

  task automatic do_read(input logic [1:0] rd_bits, input logic [10:0] lba,
                         input logic [31:0] exp_lba, input int n, input bit err_pulse);
    int t;
    bit ok;
    request(rd_bits, 2'b00, lba, t);
    ifc.sdc_lba = lba + 11'd2;
    issue_wait(t + 2, 1'b0, exp_lba, ok);
    if (ok) drv_read(n, 1'b1, err_pulse);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1);
  end

  initial begin
    int  t;
    bit  ok;
    reset              = 1'b1;
    ifc.img_present    = 2'b11;
    ifc.img_size_in    = 32'd819200;
    ifc.sdc_rd         = 2'b00;
    ifc.sdc_wr         = 2'b00;
    ifc.sdc_lba        = '0;
    ifc.sd_busy        = 1'b0;
    ifc.sd_rdata       = '0;
    ifc.sd_rdata_valid = 1'b0;
    ifc.sd_wdata_req   = 1'b0;
    ifc.sd_done        = 1'b0;
    ifc.sd_err         = 1'b0;

    #12;
    check_all_zero("reset");
    tick();
    reset = 1'b0;
    tick();
    check("mounted_copy", 32'(ifc.sdc_image_mounted), 32'd3);
    check("size_copy", ifc.sdc_image_size, 32'd819200);
    check("err_after_reset", 32'(ifc.err), 32'd0);

    // Full read from drive 0, sector 5.
    do_read(2'b01, 11'd5, 32'd5, 512, 1'b0);
    release_req();
    check("read0_err", 32'(ifc.err), 32'd0);

    // Full write to drive 1, sector 3.
    request(2'b00, 2'b10, 11'd3, t);
    issue_wait(t + 2, 1'b1, 32'd1603, ok);
    if (ok) drv_write(512);
    release_req();
    check("write1_err", 32'(ifc.err), 32'd0);

    // Both drives request: drive 0 first; bit 1 held keeps the server in release.
    request(2'b11, 2'b00, 11'd9, t);
    issue_wait(t + 2, 1'b0, 32'd9, ok);
    if (ok) drv_read(512, 1'b1, 1'b0);
    tick();
    ifc.sdc_rd = 2'b10;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("busy_held_by_bit1", 32'(ifc.sdc_busy), 32'd1);
      check("no_new_issue", 32'(ifc.sd_rd | ifc.sd_wr), 32'd0);
    end
    release_req();
    do_read(2'b10, 11'd9, 32'd1609, 512, 1'b0);
    release_req();
    check("arb_err", 32'(ifc.err), 32'd0);

    // Out-of-range read: zero sector from FILL, card untouched.
    request(2'b01, 2'b00, 11'd1600, t);
    for (int i = 0; i < 512; i++)
      rd_q.push_back('{cyc: t + 2 + i, addr: 9'(i), data: 8'h00});
    dn_q.push_back(t + 514);
    for (int k = 0; k < 514; k++) begin
      tick();
      check("fill_no_sd_req", 32'(ifc.sd_rd | ifc.sd_wr), 32'd0);
    end
    release_req();
    check("fill_err", 32'(ifc.err), 32'd0);

    // Out-of-range write: straight to done.
    request(2'b00, 2'b01, 11'd1600, t);
    dn_q.push_back(t + 1);
    release_req();
    check("oor_write_no_sd_wr", 32'(ifc.sd_wr), 32'd0);
    check("oor_write_err", 32'(ifc.err), 32'd0);

    // Short transfer flags err, which then survives a clean read.
    do_read(2'b01, 11'd7, 32'd7, 100, 1'b0);
    release_req();
    check("short_err", 32'(ifc.err), 32'd1);
    do_read(2'b01, 11'd8, 32'd8, 512, 1'b0);
    release_req();
    check("err_sticky", 32'(ifc.err), 32'd1);

    // Reset in the middle of a read stream.
    request(2'b10, 2'b00, 11'd2, t);
    issue_wait(t + 2, 1'b0, 32'd1602, ok);
    if (ok) drv_read(50, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check_all_zero("midxfer_reset");
    rd_q.delete();
    wa_q.delete();
    wd_q.delete();
    dn_q.delete();
    ifc.sd_busy = 1'b0;
    ifc.sdc_rd  = 2'b00;
    tick();
    tick();
    reset = 1'b0;
    tick();
    do_read(2'b01, 11'd5, 32'd5, 512, 1'b0);
    release_req();
    check("after_reset_err", 32'(ifc.err), 32'd0);

    // Request for an unmounted drive.
    ifc.img_present = 2'b01;
    tick();
    request(2'b00, 2'b10, 11'd4, t);
    dn_q.push_back(t + 1);
    release_req();
    check("unmounted_no_sd_wr", 32'(ifc.sd_wr), 32'd0);
    check("unmounted_err", 32'(ifc.err), 32'd1);
    check("mounted_follows", 32'(ifc.sdc_image_mounted), 32'd1);

    check("rd_q_drained", rd_q.size(), 32'd0);
    check("wd_q_drained", wd_q.size(), 32'd0);
    check("dn_q_drained", dn_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/sd_sector_server.md
# sd_sector_server

Responder for the floppy sector request interface raised by the Mac core. It accepts per-drive sector read/write requests (`sdc_rd`/`sdc_wr` with an image-relative `sdc_lba`), translates them to absolute card sectors, and drives a byte-stream SD block driver. Read data is streamed back to the core with `sdc_data_en`/`sdc_addr`; write data is fetched from the core by address. It sits between the `macplus` top and the SD card driver, and also publishes mount status and image size.

## Interface

- `DRIVES`, 2: number of floppy images; fixed at 2.
- `IMG_BASE0`, 32'd0: absolute card sector of drive 0 image.
- `IMG_BASE1`, 32'd1600: absolute card sector of drive 1 image.

- `clk` in 1: system clock; everything is synchronous to its rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `img_present` in 2: per-drive image-present level, from the card layer.
- `img_size_in` in 32: image byte size; applies to both drives.
- `sdc_image_mounted` out 2: registered copy of `img_present`.
- `sdc_image_size` out 32: registered copy of `img_size_in`.
- `sdc_rd` in 2: per-drive read request level.
- `sdc_wr` in 2: per-drive write request level.
- `sdc_lba` in 11: sector index within the image.
- `sdc_busy` out 1: request accepted and not yet released.
- `sdc_done` out 1: one-cycle completion pulse.
- `sdc_data_in` out 8: read byte to the core.
- `sdc_data_en` out 1: read byte strobe.
- `sdc_addr` out 9: byte index within the sector, for both directions.
- `sdc_data_out` in 8: write byte from the core.
- `sd_lba` out 32: absolute card sector.
- `sd_rd` out 1: driver read request level.
- `sd_wr` out 1: driver write request level.
- `sd_busy` in 1: driver busy level.
- `sd_rdata` in 8: driver read byte.
- `sd_rdata_valid` in 1: driver read byte strobe.
- `sd_wdata_req` in 1: driver requests the next write byte.
- `sd_wdata` out 8: write byte to the driver.
- `sd_wdata_valid` out 1: write byte strobe.
- `sd_done` in 1: driver completion pulse.
- `sd_err` in 1: driver error pulse; may coincide with `sd_done`.
- `err` out 1: sticky error flag; cleared only by reset.

## Operation

- **Reset:**
  - All outputs are 0, including the mount and size copies. They are refreshed every cycle after reset.
  - The FSM goes to IDLE and the byte counter `cnt` (9 bits) goes to 0.
- **IDLE:**
  - Waits for any `sdc_rd | sdc_wr` bit.
  - Arbitration: drive 0 beats drive 1. Read beats write on the same drive.
  - On acceptance, latch drive, direction and `sdc_lba`; set `sdc_busy`; clear `cnt`.
  - A request for a drive whose `img_present` bit is 0 goes to DONE with `err` set.
  - Range check: if `sdc_lba*512 >= img_size_in`, a read goes to FILL and a write goes to DONE. Neither sets `err`. The multiply is computed in 32 bits.
  - Otherwise go to ISSUE.
- **ISSUE:**
  - Set `sd_lba = base + lba` in 32-bit unsigned arithmetic with no overflow check. `base` is `IMG_BASE0` or `IMG_BASE1` for the latched drive.
  - Assert `sd_rd` or `sd_wr` and hold it until `sd_busy` is seen high, then drop it and go to XFER.
- **XFER (read):**
  - Each `sd_rdata_valid` produces one `sdc_data_en` pulse with `sdc_data_in = sd_rdata` and `sdc_addr = cnt`; then `cnt` increments.
  - Bytes beyond 512 are dropped and `err` is set.
- **XFER (write):**
  - Each `sd_wdata_req` drives `sdc_addr = cnt`, then `cnt` increments.
  - `sdc_data_out` is captured and forwarded on `sd_wdata` with `sd_wdata_valid`.
- **Exit from XFER:**
  - On `sd_done`, go to DONE.
  - `err` is set if `sd_err` is asserted, or if fewer than 512 bytes were transferred (tracked by a 10-bit tally).
- **FILL:** emit 512 zero bytes, one per cycle, with addresses 0..511, then go to DONE.
- **DONE:** pulse `sdc_done` for one cycle and go to RELEASE.
- **RELEASE:** `sdc_busy` stays high until all `sdc_rd`/`sdc_wr` bits are 0, then go to IDLE.
- **Ignored inputs:**
  - Changes to `sdc_lba` or the request bits after acceptance are ignored.
  - `img_present` changes during a transfer do not abort it.

## Timing

- `sdc_busy` rises 1 cycle after the request is sampled in IDLE.
- `sd_rd`/`sd_wr` rise 2 cycles after the request is sampled in IDLE.
- Read path: `sd_rdata_valid` in cycle N gives `sdc_data_en` in N+1.
- Write path:
  - `sd_wdata_req` in cycle N puts `sdc_addr` out in N+1.
  - `sdc_data_out` is sampled at the end of N+1 and presented as `sd_wdata_valid` in N+2.
  - Back-to-back requests are pipelined.
  - The driver must tolerate this 2-cycle latency.
- `sdc_done` is asserted 1 cycle after `sd_done`, or 1 cycle after the 512th FILL byte.
- Between two transfers there is at least 1 IDLE cycle.
- Asynchronous reset mid-transfer drops `sd_rd`/`sd_wr` immediately. The driver must be reset with the same signal.

## Structure

- Shared package `sdc_pkg`:
  - state enum `{IDLE, ISSUE, XFER, FILL, DONE, RELEASE}`
  - `SECTOR_BYTES = 512`
  - `LBA_W = 11`
- Single module with no sub-module; the write-data pipeline is two registers inline.

## Test plan

- **Read, drive 0:** `sdc_rd=2'b01`, `lba=5` → `sd_lba=5`. Model streams bytes `i^8'hA5` → 512 strobes with addresses 0..511 and matching data, one `sdc_done`, `err=0`.
- **Write, drive 1:** `sdc_wr=2'b10`, `lba=3` → `sd_lba=1603`. Model issues 512 `sd_wdata_req`; core returns `addr[7:0]` → `sd_wdata` sequence 0..255,0..255, each at N+2.
- **Simultaneous requests:** `sdc_rd=2'b11` → drive 0 served first. Keep only bit 1 high after done → drive 1 served after release.
- **Out of range:** `img_size_in=819200`, `lba=1600`, read → no `sd_rd`, 512 zero bytes, `sdc_done`, `err=0`.
- **Short transfer:** model sends 100 bytes then `sd_done` → `sdc_done` pulse, `err=1`, which persists until reset.
- **Reset mid-XFER:** reset → all outputs 0 in the same cycle. New read after reset completes normally.
